// File: rtl/sprite_pixel_shifter_bank.sv
// sprite_pixel_shifter_bank
//   Bank of CHANNELS pixel shift engines feeding a registered priority /
//   transparency resolver. Each channel captures a WORD_W-bit word of
//   BPP-bit pixels (optionally pixel-reversed), waits load_x pixel strobes,
//   then emits PIX = WORD_W/BPP pixels, one per pixel_en.
//
// Ports
//   clk, reset        pixel clock, asynchronous active-low reset
//   line_start        abort all channels, clear collision
//   pixel_en          pixel strobe; channels advance only when high
//   load/load_sel     capture strobe and per-channel select
//   load_data/_x/_flip  word, X delay, reverse pixel order
//   ch_pix/ch_active  registered pixel and SHIFT flag per channel
//   win_valid/idx/pix lowest-index non-transparent channel (1 clk behind)
//   collision         sticky: >= 2 non-transparent pixels in one cycle
module sprite_pixel_shifter_bank #(
   parameter int CHANNELS = 8,
   parameter int WORD_W   = 32,
   parameter int BPP      = 2,
   parameter int X_W      = 9,
   parameter int IDX_W    = ($clog2(CHANNELS) < 1) ? 1 : $clog2(CHANNELS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     line_start,
   input  logic                     pixel_en,
   input  logic                     load,
   input  logic [CHANNELS-1:0]      load_sel,
   input  logic [WORD_W-1:0]        load_data,
   input  logic [X_W-1:0]           load_x,
   input  logic                     load_flip,
   output logic [CHANNELS*BPP-1:0]  ch_pix,
   output logic [CHANNELS-1:0]      ch_active,
   output logic                     win_valid,
   output logic [IDX_W-1:0]         win_idx,
   output logic [BPP-1:0]           win_pix,
   output logic                     collision
);

   localparam int PIX    = WORD_W / BPP;
   localparam int LEFT_W = $clog2(PIX + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SHIFT} state_e;

   logic [CHANNELS-1:0][BPP-1:0] pix_all;
   logic [CHANNELS-1:0]          act_all;
   logic [WORD_W-1:0]            flip_data;

   // Pixel-reversed form of the load word, shared by every channel.
   always_comb begin
      flip_data = '0;
      for (int k = 0; k < PIX; k++)
         flip_data[(PIX-1-k)*BPP +: BPP] = load_data[k*BPP +: BPP];
   end

   // ---------------------------------------------------------------------
   // Per-channel shift engines
   // ---------------------------------------------------------------------
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      state_e              state_q, state_d;
      logic [WORD_W-1:0]   buf_q, buf_d;
      logic [X_W-1:0]      xcnt_q, xcnt_d;
      logic [LEFT_W-1:0]   left_q, left_d;
      logic [BPP-1:0]      pix_q, pix_d;

      always_comb begin
         state_d = state_q;
         buf_d   = buf_q;
         xcnt_d  = xcnt_q;
         left_d  = left_q;
         pix_d   = pix_q;
         // line_start beats load, load beats pixel_en: a load-cycle strobe
         // is never counted toward the X delay.
         if (line_start) begin
            state_d = ST_IDLE;
            pix_d   = '0;
         end else if (load && load_sel[c]) begin
            buf_d   = load_flip ? flip_data : load_data;
            xcnt_d  = load_x;
            state_d = ST_WAIT;
            pix_d   = '0;
         end else if (pixel_en) begin
            case (state_q)
               ST_WAIT: begin
                  if (xcnt_q != '0) begin
                     xcnt_d = xcnt_q - X_W'(1);
                  end else begin
                     pix_d   = buf_q[BPP-1:0];
                     buf_d   = buf_q >> BPP;
                     left_d  = LEFT_W'(PIX - 1);
                     state_d = ST_SHIFT;
                  end
               end
               ST_SHIFT: begin
                  if (left_q != '0) begin
                     pix_d  = buf_q[BPP-1:0];
                     buf_d  = buf_q >> BPP;
                     left_d = left_q - LEFT_W'(1);
                  end else begin
                     pix_d   = '0;
                     state_d = ST_IDLE;
                  end
               end
               default: pix_d = '0;
            endcase
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            xcnt_q  <= '0;
            left_q  <= '0;
            pix_q   <= '0;
         end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            xcnt_q  <= xcnt_d;
            left_q  <= left_d;
            pix_q   <= pix_d;
         end
      end

      assign pix_all[c] = pix_q;
      assign act_all[c] = (state_q == ST_SHIFT);
   end

   assign ch_pix    = pix_all;
   assign ch_active = act_all;

   // ---------------------------------------------------------------------
   // Priority / transparency resolver
   // ---------------------------------------------------------------------
   logic [CHANNELS-1:0] cand;
   logic                multi;
   logic                win_valid_q, win_valid_d;
   logic [IDX_W-1:0]    win_idx_q, win_idx_d;
   logic [BPP-1:0]      win_pix_q, win_pix_d;
   logic                collision_q, collision_d;

   always_comb begin
      win_idx_d = '0;
      win_pix_d = '0;
      for (int c = 0; c < CHANNELS; c++)
         cand[c] = act_all[c] && (pix_all[c] != '0);
      // Walk high to low so the lowest-index candidate wins.
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (cand[c]) begin
            win_idx_d = IDX_W'(c);
            win_pix_d = pix_all[c];
         end
      end
      // Clearing the lowest set bit leaves something iff >= 2 candidates.
      multi       = |(cand & (cand - CHANNELS'(1)));
      win_valid_d = |cand;
      collision_d = line_start ? 1'b0 : (collision_q | multi);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_valid_q <= 1'b0;
         win_idx_q   <= '0;
         win_pix_q   <= '0;
         collision_q <= 1'b0;
      end else begin
         win_valid_q <= win_valid_d;
         win_idx_q   <= win_idx_d;
         win_pix_q   <= win_pix_d;
         collision_q <= collision_d;
      end
   end

   assign win_valid = win_valid_q;
   assign win_idx   = win_idx_q;
   assign win_pix   = win_pix_q;
   assign collision = collision_q;

endmodule

// File: tb/tb_sprite_pixel_shifter_bank.sv
// Directed bench for sprite_pixel_shifter_bank: a default 8-channel 2-bpp
// instance (a) and a 3-channel 24-bit 4-bpp instance (b).
module tb_sprite_pixel_shifter_bank;

   logic clk, reset;
   int   checks = 0;
   int   errs   = 0;

   // instance a: defaults
   logic        ls_a, pe_a, ld_a, flip_a;
   logic [7:0]  sel_a;
   logic [31:0] data_a;
   logic [8:0]  x_a;
   logic [15:0] chpix_a;
   logic [7:0]  act_a;
   logic        wv_a, col_a;
   logic [2:0]  widx_a;
   logic [1:0]  wpix_a;

   // instance b: 3 channels, 24-bit words, 4 bpp
   logic        ls_b, pe_b, ld_b, flip_b;
   logic [2:0]  sel_b;
   logic [23:0] data_b;
   logic [8:0]  x_b;
   logic [11:0] chpix_b;
   logic [2:0]  act_b;
   logic        wv_b, col_b;
   logic [1:0]  widx_b;
   logic [3:0]  wpix_b;

   sprite_pixel_shifter_bank u_a (
      .clk(clk), .reset(reset), .line_start(ls_a), .pixel_en(pe_a),
      .load(ld_a), .load_sel(sel_a), .load_data(data_a), .load_x(x_a),
      .load_flip(flip_a), .ch_pix(chpix_a), .ch_active(act_a),
      .win_valid(wv_a), .win_idx(widx_a), .win_pix(wpix_a),
      .collision(col_a));

   sprite_pixel_shifter_bank #(.CHANNELS(3), .WORD_W(24), .BPP(4)) u_b (
      .clk(clk), .reset(reset), .line_start(ls_b), .pixel_en(pe_b),
      .load(ld_b), .load_sel(sel_b), .load_data(data_b), .load_x(x_b),
      .load_flip(flip_b), .ch_pix(chpix_b), .ch_active(act_b),
      .win_valid(wv_b), .win_idx(widx_b), .win_pix(wpix_b),
      .collision(col_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int prev, e;
      reset = 1'b0;
      {ls_a, pe_a, ld_a, flip_a, sel_a, data_a, x_a} = '0;
      {ls_b, pe_b, ld_b, flip_b, sel_b, data_b, x_b} = '0;
      tick(); tick();
      chk("rst_chpix", chpix_a, 0);
      chk("rst_act",   act_a,   0);
      chk("rst_win",   {wv_a, widx_a, wpix_a, col_a}, 0);
      chk("rst_b",     {chpix_b, act_b, wv_b, col_b}, 0);
      reset = 1'b1;
      tick();

      // strobes alone produce nothing
      pe_a = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("idle", {chpix_a, act_a, wv_a, col_a}, 0);
      end

      // basic shift on ch0, load-cycle strobe ignored
      ld_a = 1'b1; sel_a = 8'h01; data_a = 32'h1B1B1B1B; x_a = 0; flip_a = 0;
      tick();
      ld_a = 1'b0;
      chk("bs_wait_act", act_a, 0);
      prev = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         e = 3 - (i % 4);
         chk("bs_pix",  chpix_a[1:0], e);
         chk("bs_act",  act_a, 8'h01);
         chk("bs_wv",   wv_a, (prev != 0));
         chk("bs_widx", widx_a, 0);
         chk("bs_wpix", wpix_a, prev);
         prev = e;
      end
      tick();
      chk("bs_end_act", act_a, 0);
      chk("bs_end_pix", chpix_a, 0);
      chk("bs_end_wv",  wv_a, 0);

      // asynchronous reset in the middle of a shift
      ld_a = 1'b1;
      tick();
      ld_a = 1'b0;
      tick(); tick(); tick();
      chk("pre_rst_wv",   wv_a, 1);
      chk("pre_rst_wpix", wpix_a, 2);
      #2 reset = 1'b0;
      #1;
      chk("arst_chpix", chpix_a, 0);
      chk("arst_act",   act_a, 0);
      chk("arst_win",   {wv_a, widx_a, wpix_a, col_a}, 0);
      tick();
      reset = 1'b1;
      tick();

      // X delay 5 with strobe gaps, flipped word
      ld_a = 1'b1; sel_a = 8'h08; data_a = 32'h1; x_a = 5; flip_a = 1;
      tick();
      ld_a = 1'b0; flip_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pe_a = 1'b0;
         tick();
         chk("xw_gap_act", act_a[3], 0);
         pe_a = 1'b1;
         tick();
         chk("xw_act", act_a[3], 0);
      end
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("fl_act", act_a[3], 1);
         chk("fl_pix", chpix_a[7:6], 0);
      end
      tick();
      chk("fl_last_pix", chpix_a[7:6], 1);
      chk("fl_last_act", act_a[3], 1);
      tick();
      chk("fl_done_act", act_a[3], 0);
      chk("fl_done_pix", chpix_a, 0);
      chk("fl_win", {wv_a, widx_a, wpix_a}, {1'b1, 3'd3, 2'd1});
      tick();
      chk("fl_win_off", wv_a, 0);

      // ch2 and ch5 emit 2 together
      ld_a = 1'b1; sel_a = 8'h24; data_a = 32'h2; x_a = 0;
      tick();
      ld_a = 1'b0;
      tick();
      chk("co_pix2", chpix_a[5:4], 2);
      chk("co_pix5", chpix_a[11:10], 2);
      chk("co_col_early", col_a, 0);
      tick();
      chk("co_win", {wv_a, widx_a, wpix_a}, {1'b1, 3'd2, 2'd2});
      chk("co_col", col_a, 1);
      for (int i = 0; i < 20; i++) tick();
      chk("co_idle_act", act_a, 0);
      chk("co_sticky", col_a, 1);
      pe_a = 1'b0; ls_a = 1'b1;
      tick();
      ls_a = 1'b0;
      chk("co_clear", col_a, 0);

      // line_start beats load
      pe_a = 1'b1; ls_a = 1'b1; ld_a = 1'b1; sel_a = 8'h02; data_a = 32'hFFFFFFFF;
      tick();
      ls_a = 1'b0; ld_a = 1'b0;
      tick();
      chk("lsld_act", act_a, 0);
      chk("lsld_pix", chpix_a, 0);

      // reload during SHIFT restarts WAIT with new X
      ld_a = 1'b1; sel_a = 8'h01; data_a = 32'h1B1B1B1B; x_a = 0;
      tick();
      ld_a = 1'b0;
      tick();
      chk("rl_act0", act_a, 8'h01);
      chk("rl_pix0", chpix_a[1:0], 3);
      ld_a = 1'b1; data_a = 32'hFFFFFFFF; x_a = 2;
      tick();
      ld_a = 1'b0;
      chk("rl_wait_act", act_a[0], 0);
      chk("rl_wait_pix", chpix_a[1:0], 0);
      tick();
      chk("rl_x1", act_a[0], 0);
      tick();
      chk("rl_x0", act_a[0], 0);
      tick();
      chk("rl_go_act", act_a[0], 1);
      chk("rl_go_pix", chpix_a[1:0], 3);
      ls_a = 1'b1; pe_a = 1'b0;
      tick();
      ls_a = 1'b0;
      chk("rl_abort", act_a, 0);

      // 3 ch / 24 bit / 4 bpp: nibble order on ch2
      ld_b = 1'b1; sel_b = 3'b100; data_b = 24'h654321; x_b = 0; flip_b = 0;
      pe_b = 1'b1;
      tick();
      ld_b = 1'b0;
      prev = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("pb_pix",  chpix_b[11:8], i + 1);
         chk("pb_act",  act_b, 3'b100);
         chk("pb_widx", widx_b, (prev != 0) ? 2 : 0);
         chk("pb_wpix", wpix_b, prev);
         prev = i + 1;
      end
      tick();
      chk("pb_end_act", act_b, 0);
      chk("pb_end_win", {wv_b, widx_b, wpix_b}, {1'b1, 2'd2, 4'd6});

      // flipped nibbles on ch0
      ld_b = 1'b1; sel_b = 3'b001; flip_b = 1'b1;
      tick();
      ld_b = 1'b0; flip_b = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("pbf_pix", chpix_b[3:0], 6 - i);
      end
      tick();
      chk("pbf_end_act", act_b, 0);
      chk("pbf_col", col_b, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
